// File: rtl/cache_ctrl_pkg.sv
// Shared types and default configuration for the write-buffered cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FILL
  } ctrl_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 2;
  localparam int DEF_IDX_W      = 17;
  localparam int DEF_BASE_ADDR  = 1024;
  localparam int DEF_WBUF_DEPTH = 4;

endpackage

// File: rtl/cache_wbuf_fifo.sv
// Posted-store FIFO of {address, data} pairs; pointers carry one extra wrap bit.
module cache_wbuf_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [31:0]       push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic              last,
  output logic [31:0]       head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    used;
  logic [31:0]       addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  assign used      = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign last      = (used == (PTR_W+1)'(1));
  assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
  assign head_data = data_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is never reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
      data_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cache_ctrl_wbuf.sv
// Cache controller with posted write buffer; stores drain to SRAM before any miss fill.
// Optional CACHE_CTRL_STATS_EN adds saturating hit/miss/stall counters.
module cache_ctrl_wbuf
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int BASE_ADDR  = DEF_BASE_ADDR,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read_en,
  input  logic                         mem_write_en,
  input  logic [31:0]                  address,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         ready,
  output logic [DATA_W-1:0]            read_data,
  input  logic                         cache_hit,
  input  logic [DATA_W-1:0]            cache_read_data,
  output logic                         cache_read_en,
  output logic                         cache_write_en,
  output logic [IDX_W-1:0]             cache_addr,
  output logic [LINE_WORDS*DATA_W-1:0] cache_write_data,
  output logic                         check_invalid,
  input  logic                         sram_ready,
  output logic                         sram_read_en,
  output logic                         sram_write_en,
  output logic [31:0]                  sram_addr,
  output logic [DATA_W-1:0]            sram_write_data,
  input  logic [LINE_WORDS*DATA_W-1:0] sram_read_data
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
  output logic [31:0]                  stall_count
`endif
);

  localparam int          WSEL_W = $clog2(LINE_WORDS);
  localparam logic [31:0] BASE_W = 32'(BASE_ADDR);

  ctrl_state_e       state;
  logic              load;
  logic              store;
  logic              load_hit;
  logic              load_miss;
  logic              push;
  logic              pop;
  logic              fill_done;
  logic              full;
  logic              empty;
  logic              last;
  logic [31:0]       head_addr;
  logic [DATA_W-1:0] head_data;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] word_sel;

  // A simultaneous read and write request is serviced as a load only.
  assign load      = mem_read_en;
  assign store     = mem_write_en & ~mem_read_en;
  assign load_hit  = load & cache_hit & (state != ST_FILL);
  assign load_miss = load & ~cache_hit;
  assign push      = store & ~full;
  assign pop       = (state == ST_DRAIN) & sram_ready;
  assign fill_done = (state == ST_FILL) & sram_ready;

  assign idx      = IDX_W'(({address[31:2], 2'b00} - BASE_W) >> 2);
  assign word_sel = WSEL_W'(address >> 2);

  cache_wbuf_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (address),
    .push_data (write_data),
    .full      (full),
    .empty     (empty),
    .last      (last),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // A fill may only start once every older store has reached SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_miss && empty)   state <= ST_FILL;
          else if (!empty || push)  state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (sram_ready) begin
            if (!last || push)      state <= ST_DRAIN;
            else if (load_miss)     state <= ST_FILL;
            else                    state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (sram_ready)           state <= ST_IDLE;
        end
        default:                    state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready            = 1'b1;
    read_data        = '0;
    cache_read_en    = 1'b0;
    cache_write_en   = 1'b0;
    cache_addr       = '0;
    cache_write_data = '0;
    check_invalid    = 1'b0;
    sram_read_en     = 1'b0;
    sram_write_en    = 1'b0;
    sram_addr        = '0;
    sram_write_data  = '0;

    if (load || store) cache_addr = idx;

    // A full buffer refuses the store even if a pop frees a slot this cycle.
    if (store) begin
      ready         = ~full;
      check_invalid = ~full;
    end

    if (load) begin
      if (state == ST_FILL) begin
        ready = fill_done;
        if (fill_done) begin
          cache_write_en   = 1'b1;
          cache_write_data = sram_read_data;
          read_data        = sram_read_data[word_sel*DATA_W +: DATA_W];
        end
      end else if (load_hit) begin
        cache_read_en = 1'b1;
        read_data     = cache_read_data;
      end else begin
        ready = 1'b0;
      end
    end

    case (state)
      ST_DRAIN: begin
        sram_write_en   = 1'b1;
        sram_addr       = head_addr;
        sram_write_data = head_data;
      end
      ST_FILL: begin
        sram_read_en = 1'b1;
        sram_addr    = address;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count   <= '0;
      miss_count  <= '0;
      stall_count <= '0;
    end else begin
      if (load_hit)                    hit_count   <= sat_inc(hit_count);
      if (fill_done && load)           miss_count  <= sat_inc(miss_count);
      if ((load || store) && !ready)   stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_wbuf.sv
// Bench for cache_ctrl_wbuf: directed scenarios plus random traffic against a
// program-order memory model and an ordered store queue.
module tb_cache_ctrl_wbuf;

  localparam int DATA_W = 32;
  localparam int LW     = 2;
  localparam int IDX_W  = 17;
  localparam int BASE   = 1024;
  localparam int DEPTH  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mem_read_en, mem_write_en;
  logic [31:0]          address;
  logic [DATA_W-1:0]    write_data;
  logic                 ready;
  logic [DATA_W-1:0]    read_data;
  logic                 cache_hit;
  logic [DATA_W-1:0]    cache_read_data;
  logic                 cache_read_en, cache_write_en;
  logic [IDX_W-1:0]     cache_addr;
  logic [LW*DATA_W-1:0] cache_write_data;
  logic                 check_invalid;
  logic                 sram_ready, sram_read_en, sram_write_en;
  logic [31:0]          sram_addr;
  logic [DATA_W-1:0]    sram_write_data;
  logic [LW*DATA_W-1:0] sram_read_data;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0]          hit_count, miss_count, stall_count;
`endif

  always #5 clk = ~clk;

  cache_ctrl_wbuf #(
    .DATA_W(DATA_W), .LINE_WORDS(LW), .IDX_W(IDX_W), .BASE_ADDR(BASE), .WBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .address(address), .write_data(write_data),
    .ready(ready), .read_data(read_data),
    .cache_hit(cache_hit), .cache_read_data(cache_read_data),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_addr(cache_addr), .cache_write_data(cache_write_data),
    .check_invalid(check_invalid),
    .sram_ready(sram_ready), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_addr(sram_addr), .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wentry_t;

  wentry_t     wq[$];
  logic [31:0] sram_mem [int unsigned];
  logic [31:0] ref_mem  [int unsigned];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B9) ^ 32'h0F0F_0F0F;
  endfunction

  function automatic logic [31:0] sram_word(input int unsigned w);
    return sram_mem.exists(w) ? sram_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [LW*DATA_W-1:0] line_of(input logic [31:0] a);
    logic [LW*DATA_W-1:0] l;
    int unsigned base;
    base = (a >> 2) & ~(LW - 1);
    for (int i = 0; i < LW; i++) l[i*DATA_W +: DATA_W] = sram_word(base + i);
    return l;
  endfunction

  function automatic logic [31:0] exp_idx(input logic [31:0] a);
    logic [31:0] rel;
    rel = (a & 32'hFFFF_FFFC) - 32'(BASE);
    return (rel >> 2) & ((32'd1 << IDX_W) - 1);
  endfunction

  task automatic sample();
    @(negedge clk);
    sram_read_data = line_of(sram_addr);
    #1;
  endtask

  // Checks the current cycle against the model, applies its effects, advances one clock.
  task automatic commit();
    wentry_t e;
    if (mem_read_en) begin
      check_eq("ld_cache_addr", cache_addr, exp_idx(address));
      if (mem_write_en) check_eq("rw_no_inval", check_invalid, 0);
      if (cache_hit) begin
        check_eq("hit_ready", ready, 1);
        check_eq("hit_rd_en", cache_read_en, 1);
        check_eq("hit_data", read_data, cache_read_data);
      end else if (ready) begin
        check_eq("fill_rd_en", sram_read_en, 1);
        check_eq("fill_cwe", cache_write_en, 1);
        check_eq("fill_data", read_data, ref_word(address >> 2));
        check_eq("fill_line", cache_write_data, line_of(address));
      end else begin
        check_eq("miss_cwe", cache_write_en, 0);
      end
    end else if (mem_write_en) begin
      check_eq("st_cache_addr", cache_addr, exp_idx(address));
      check_eq("st_ready", ready, wq.size() < DEPTH);
      check_eq("st_inval", check_invalid, wq.size() < DEPTH);
    end else begin
      check_eq("idle_ready", ready, 1);
      check_eq("idle_outs", {cache_read_en, cache_write_en, check_invalid}, 0);
      check_eq("idle_rdata", read_data, 0);
    end
    if (sram_read_en) check_eq("fill_after_drain", wq.size(), 0);
    if (sram_write_en) begin
      if (wq.size() == 0) begin
        check_eq("spurious_write", sram_write_en, 0);
      end else begin
        check_eq("wr_addr", sram_addr, wq[0].addr);
        check_eq("wr_data", sram_write_data, wq[0].data);
        if (sram_ready) begin
          e = wq.pop_front();
          sram_mem[e.addr >> 2] = e.data;
        end
      end
    end
    if (mem_write_en && !mem_read_en && ready) begin
      e.addr = address;
      e.data = write_data;
      wq.push_back(e);
      ref_mem[address >> 2] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    mem_read_en = 0;
    mem_write_en = 0;
    while (wq.size() > 0 && n < 50) begin
      sram_ready = 1;
      sample();
      commit();
      n++;
    end
    sram_ready = 0;
    if (n >= 50) check_eq("drain_timeout", wq.size(), 0);
  endtask

  int   k, wait_n, n;
  logic busy, done, seen_rd;

  initial begin
    rst = 1; mem_read_en = 0; mem_write_en = 0; address = 0; write_data = 0;
    cache_hit = 0; cache_read_data = 0; sram_ready = 0; sram_read_data = 0;
    @(posedge clk); #1;
    sample();
    check_eq("rst_ready", ready, 1);
    check_eq("rst_sram", {sram_read_en, sram_write_en}, 0);
    check_eq("rst_sram_addr", sram_addr, 0);
    commit();
    rst = 0;

    // Single posted store: same-cycle accept, SRAM write the next cycle.
    mem_write_en = 1; address = 32'h0000_0404; write_data = 32'hDEAD_BEEF;
    sample();
    check_eq("st1_ready", ready, 1);
    check_eq("st1_inval", check_invalid, 1);
    check_eq("st1_idx", cache_addr, 1);
    commit();
    mem_write_en = 0;
    sample();
    check_eq("st1_wen", sram_write_en, 1);
    check_eq("st1_waddr", sram_addr, 32'h0000_0404);
    check_eq("st1_wdata", sram_write_data, 32'hDEAD_BEEF);
    commit();
    drain_all();

    // Five back-to-back stores with SRAM stalled: the fifth waits for a pop.
    for (int i = 0; i < 5; i++) begin
      mem_write_en = 1; address = 32'h500 + 4 * i; write_data = 32'hA000_0000 + i;
      sample();
      check_eq($sformatf("bb_ready%0d", i), ready, i < 4);
      if (i < 4) commit();
    end
    commit();
    sample(); check_eq("bb_full_hold", ready, 0); commit();
    sram_ready = 1;
    sample(); check_eq("bb_pop_cycle", ready, 0); commit();
    sram_ready = 0;
    sample(); check_eq("bb_admit", ready, 1); commit();
    drain_all();

    // Miss fill with a three-cycle SRAM latency.
    sram_mem[32'h408 >> 2] = 32'h1111_1111; sram_mem[32'h40C >> 2] = 32'h2222_2222;
    ref_mem[32'h408 >> 2]  = 32'h1111_1111; ref_mem[32'h40C >> 2]  = 32'h2222_2222;
    mem_read_en = 1; address = 32'h408; cache_hit = 0; sram_ready = 0;
    sample(); check_eq("miss_ready0", ready, 0); commit();
    sample(); check_eq("miss_rd_en", sram_read_en, 1); check_eq("miss_raddr", sram_addr, 32'h408); commit();
    sample(); commit();
    sram_ready = 1;
    sample();
    check_eq("miss_ready1", ready, 1);
    check_eq("miss_rdata", read_data, 32'h1111_1111);
    check_eq("miss_cwe", cache_write_en, 1);
    check_eq("miss_line", cache_write_data, {32'h2222_2222, 32'h1111_1111});
    commit();
    mem_read_en = 0; sram_ready = 0;
    sample(); check_eq("miss_back_idle", sram_read_en, 0); commit();

    // Address below the data base wraps the index.
    mem_read_en = 1; cache_hit = 1; address = 32'h0000_0002; cache_read_data = 32'h1234_5678;
    sample(); check_eq("wrap_idx", cache_addr, 17'h1FF00); check_eq("wrap_hit", read_data, 32'h1234_5678); commit();
    mem_read_en = 0; cache_hit = 0;

    // Load miss behind two buffered stores must see the first store's data.
    mem_write_en = 1; address = 32'h410; write_data = 32'hCAFE_0001; sample(); commit();
    address = 32'h414; write_data = 32'hCAFE_0002; sample(); commit();
    mem_write_en = 0; mem_read_en = 1; address = 32'h410; cache_hit = 0;
    done = 0; seen_rd = 0; n = 0;
    while (!done && n < 30) begin
      sram_ready = n[0];
      sample();
      if (sram_read_en && !seen_rd) begin
        seen_rd = 1;
        check_eq("raw_drained", wq.size(), 0);
      end
      if (ready) begin
        check_eq("raw_data", read_data, 32'hCAFE_0001);
        done = 1;
      end
      commit();
      n++;
    end
    check_eq("raw_done", done, 1);
    mem_read_en = 0; sram_ready = 0;

    // Reset in the middle of a drain discards the buffer.
    for (int i = 0; i < 3; i++) begin
      mem_write_en = 1; address = 32'h600 + 4 * i; write_data = 32'hB000_0000 + i;
      sample(); commit();
    end
    mem_write_en = 0; rst = 1;
    sample();
    check_eq("mid_rst_wen", sram_write_en, 0);
    check_eq("mid_rst_ready", ready, 1);
    wq.delete();
    ref_mem = sram_mem;
    commit();
    rst = 0;
    mem_write_en = 1; address = 32'h700; write_data = 32'h7777_0000;
    sample(); check_eq("post_rst_ready", ready, 1); check_eq("post_rst_inval", check_invalid, 1); commit();
    mem_write_en = 0;
    sample(); check_eq("post_rst_wen", sram_write_en, 1); check_eq("post_rst_waddr", sram_addr, 32'h700); commit();
    drain_all();

    // Random traffic; a stalled request is held until ready.
    busy = 0; wait_n = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) begin
        k = $urandom_range(0, 9);
        mem_read_en  = (k >= 6);
        mem_write_en = (k >= 2 && k < 6) || k == 9;
        address      = 32'h400 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        write_data   = $urandom;
        cache_hit    = ($urandom_range(0, 1) == 1);
        cache_read_data = $urandom;
        wait_n = 0;
      end
      sram_ready = ($urandom_range(0, 2) == 0);
      sample();
      if ((mem_read_en || mem_write_en) && !ready) begin
        busy = 1;
        wait_n++;
      end else begin
        busy = 0;
      end
      if (wait_n > 200) begin
        check_eq("req_timeout", wait_n, 0);
        busy = 0;
      end
      commit();
    end
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_ctrl_wbuf.md
CACHE_CTRL_WBUF -- requirements
Module: cache_ctrl_wbuf

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 32, word width; LINE_WORDS, 2, words per line (power of 2, ≥2); IDX_W, 17, cache index width; BASE_ADDR, 1024, data-memory base subtracted from address; WBUF_DEPTH, 4, write-buffer entries (power of 2, ≥2).
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high; mem_read_en in 1 load request; mem_write_en in 1 store request; address in 32 byte address; write_data in DATA_W store data; ready out 1 request complete/stall release; read_data out DATA_W load data; cache_hit in 1 lookup hit; cache_read_data in DATA_W hit data; cache_read_en out 1; cache_write_en out 1 line fill; cache_addr out IDX_W word index; cache_write_data out LINE_WORDS*DATA_W fill line; check_invalid out 1 invalidate-on-store; sram_ready in 1 SRAM done; sram_read_en out 1; sram_write_en out 1; sram_addr out 32; sram_write_data out DATA_W; sram_read_data in LINE_WORDS*DATA_W.

Function
REQ-003 cache_addr SHALL be bits [IDX_W+1:2] of ({address[31:2],2'b00} − BASE_ADDR), truncated mod 2^32.
REQ-004 States SHALL be IDLE, DRAIN, FILL; a store SHALL be posted to a WBUF_DEPTH FIFO of {address, write_data} pairs.
REQ-005 Store, buffer not full: push, check_invalid=1 and ready=1 in the same cycle, in any state; store with buffer full: no push, ready=0, check_invalid=0 (a pop in that cycle does not admit it).
REQ-006 Load with cache_hit in IDLE or DRAIN: cache_read_en=1, read_data=cache_read_data, ready=1 in the same cycle.
REQ-007 Load miss: ready=0; if buffer non-empty, drain continues until empty; then FILL.
REQ-008 IDLE→DRAIN when buffer non-empty and no load miss pending with an empty buffer; DRAIN drives sram_write_en=1, sram_addr/sram_write_data = FIFO head; on sram_ready pop head, then: buffer non-empty→DRAIN, else pending miss→FILL, else IDLE.
REQ-009 IDLE→FILL directly on load miss with empty buffer; FILL drives sram_read_en=1, sram_addr=address; on sram_ready: cache_write_en=1, cache_write_data=sram_read_data, read_data=word selected by real-address bits [log2(LINE_WORDS)+1:2], ready=1, →IDLE.
REQ-010 Loads SHALL never bypass an older buffered store (drain-before-fill guarantees RAW order).
REQ-011 mem_read_en and mem_write_en both high SHALL be treated as load only.
REQ-012 No request: ready=1; all unselected outputs SHALL be 0.
REQ-013 Full/empty SHALL be tracked with pointers one bit wider than log2(WBUF_DEPTH), wrapping naturally.

Reset
REQ-014 rst SHALL force IDLE, empty buffer (contents discarded), all outputs 0 except ready per REQ-012; an in-flight SRAM transaction is abandoned.

Configuration
REQ-015 With CACHE_CTRL_STATS_EN defined: outputs hit_count, miss_count, stall_count (32 bits each, saturating) count load hits, load misses, and cycles with ready=0 under an active request; cleared on rst. Undefined: ports and counters absent.

Structure
REQ-016 Package cache_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-017 The write buffer SHALL be sub-module cache_wbuf_fifo (push/pop/full/empty/head).

Verification
REQ-018 Store 0x0000_0404/0xDEAD_BEEF, empty buffer → ready=1, check_invalid=1 same cycle; sram_write_en next cycle with that addr/data.
REQ-019 5 back-to-back stores, sram_ready held low, WBUF_DEPTH=4 → 4 accepted, 5th ready=0 until first sram_ready pop.
REQ-020 Load 0x0000_0408 miss, sram_read_data={0x2222_2222,0x1111_1111}, sram_ready after 3 cycles → read_data=0x1111_1111, cache_write_en=1, ready=1.
REQ-021 Two stores buffered then load miss to first store address → both SRAM writes complete before sram_read_en rises.
REQ-022 rst asserted mid-DRAIN with 3 entries → next cycle IDLE, sram_write_en=0, a new store is accepted immediately.
